led_mux: RTL and testbench

Four-digit, time-multiplexed seven-segment display driver for the scoreboard on the board's common-anode display. It takes four 4-bit digit codes, scans one digit per refresh tick and drives active-low segment and anode lines. It sits beside the VGA game logic, which supplies the X score, two dash digits and the O score.

---
 rtl/led_pkg.sv | 28 ++
 rtl/led_mux_seg7_decode.sv | 32 +++
 rtl/led_mux.sv | 75 +++++++
 tb/tb_led_mux.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants for the seven-segment scoreboard driver.
// Segment patterns are active-low: bit0 = a ... bit6 = g.
package led_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = $clog2(NUM_DIGITS);

    localparam logic [3:0] DIGIT_DASH = 4'd15;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_B    = 7'b0000011;
    localparam logic [6:0] SEG_C    = 7'b1000110;
    localparam logic [6:0] SEG_D    = 7'b0100001;
    localparam logic [6:0] SEG_E    = 7'b0000110;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/led_mux_seg7_decode.sv
// Combinational hex-ish glyph decoder: 0-9, A b C d E, and 15 as a dash.
module seg7_decode
    import led_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'd0:       seg = SEG_0;
            4'd1:       seg = SEG_1;
            4'd2:       seg = SEG_2;
            4'd3:       seg = SEG_3;
            4'd4:       seg = SEG_4;
            4'd5:       seg = SEG_5;
            4'd6:       seg = SEG_6;
            4'd7:       seg = SEG_7;
            4'd8:       seg = SEG_8;
            4'd9:       seg = SEG_9;
            4'd10:      seg = SEG_A;
            4'd11:      seg = SEG_B;
            4'd12:      seg = SEG_C;
            4'd13:      seg = SEG_D;
            4'd14:      seg = SEG_E;
            DIGIT_DASH: seg = SEG_DASH;
            default:    seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/led_mux.sv
// Four-digit multiplexed common-anode display driver (active-low segments/anodes).
// Define LED_MUX_ZERO_BLANK_EN to blank leading zeros (digit 0 is never blanked).
module led_mux
    import led_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    output logic [6:0]  LED_Seg,
    output logic [3:0]  LED_Val
);

    localparam int                CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] val_q, val_d;

    logic [3:0]            cur_code;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] blank_mask;

    assign cur_code = digits[{sel_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .code (cur_code),
        .seg  (dec_seg)
    );

`ifdef LED_MUX_ZERO_BLANK_EN
    // A digit is blank when it and every digit above it are zero.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
        if (gi == 0) begin : g_first
            assign blank_mask[gi] = 1'b0;
        end else begin : g_upper
            assign blank_mask[gi] = (digits[4*NUM_DIGITS-1:4*gi] == '0);
        end
    end
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        sel_d = sel_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            sel_d = sel_q + SEL_W'(1);
        end
        seg_d = blank_mask[sel_q] ? SEG_OFF : dec_seg;
        val_d = ~(NUM_DIGITS'(1) << sel_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sel_q <= '0;
            seg_q <= SEG_OFF;
            val_q <= '1;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
            val_q <= val_d;
        end
    end

    assign LED_Seg = seg_q;
    assign LED_Val = val_q;

endmodule

// File: tb/tb_led_mux.sv
// Directed scoreboard bench for led_mux: one CLK_DIV=4 instance and one CLK_DIV=1 instance.
module tb_led_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits4 = 16'h1FF2;
    logic [15:0] digits1 = 16'h0000;
    logic [6:0]  seg4, seg1;
    logic [3:0]  val4, val1;

    always #5 clk = ~clk;

    led_mux #(.CLK_DIV(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .digits  (digits4),
        .LED_Seg (seg4),
        .LED_Val (val4)
    );

    led_mux #(.CLK_DIV(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .digits  (digits1),
        .LED_Seg (seg1),
        .LED_Val (val1)
    );

    typedef struct {
        string       tag;
        int          which;
        logic [10:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_pass = 0;
    int  n_total = 0;
    int  cyc = 0;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'd0:  return 7'h40;
            4'd1:  return 7'h79;
            4'd2:  return 7'h24;
            4'd3:  return 7'h30;
            4'd4:  return 7'h19;
            4'd5:  return 7'h12;
            4'd6:  return 7'h02;
            4'd7:  return 7'h78;
            4'd8:  return 7'h00;
            4'd9:  return 7'h10;
            4'd10: return 7'h08;
            4'd11: return 7'h03;
            4'd12: return 7'h46;
            4'd13: return 7'h21;
            4'd14: return 7'h06;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] digs, input int d);
        logic [3:0] c;
        c = digs[4*d +: 4];
`ifdef LED_MUX_ZERO_BLANK_EN
        if (d != 0 && (digs >> (4*d)) == 16'h0000) return 7'h7F;
`endif
        return glyph(c);
    endfunction

    // Push expectations for the coming edge, clock, then pop and compare.
    task automatic step(input string tag);
        sb_t e;
        int  d4, d1;
        logic [3:0] onehot;
        e.tag = tag;
        if (rst) begin
            cyc = 0;
            e.which = 4; e.exp = {7'h7F, 4'hF}; sb_q.push_back(e);
            e.which = 1; e.exp = {7'h7F, 4'hF}; sb_q.push_back(e);
        end else begin
            cyc++;
            d4 = ((cyc - 1) / 4) % 4;
            d1 = (cyc - 1) % 4;
            onehot = 4'b0001 << d4;
            e.which = 4; e.exp = {exp_seg(digits4, d4), ~onehot}; sb_q.push_back(e);
            onehot = 4'b0001 << d1;
            e.which = 1; e.exp = {exp_seg(digits1, d1), ~onehot}; sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            logic [10:0] obs;
            e = sb_q.pop_front();
            obs = (e.which == 4) ? {seg4, val4} : {seg1, val1};
            n_total++;
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s dut%0d cyc=%0d seg/val got=%b_%b expected=%b_%b",
                        e.tag, e.which, cyc, obs[10:4], obs[3:0], e.exp[10:4], e.exp[3:0]);
        end
    endtask

    initial begin
        // Reset held for three cycles: display dark.
        for (int i = 0; i < 3; i++) step("reset");

        // One full frame of 1FF2.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) step("frame");

        // Digit 0 lit again: change it from 3 to 7 mid-slot.
        digits4 = 16'h1FF3;
        step("mid3");
        digits4 = 16'h1FF7;
        for (int i = 0; i < 4; i++) step("mid7");

        // Reset at frame cycle 6, then restart from digit 0.
        rst = 1'b1;
        step("rst_pre");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step("pre_rst6");
        rst = 1'b1;
        step("midrst");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step("restart");

        // Decoder sweep on the CLK_DIV=1 instance.
        for (int k = 0; k < 16; k++) begin
            logic [3:0] kk;
            kk = 4'(k);
            digits1 = {kk, kk, kk, kk};
            step("sweep");
        end

        // Leading-zero cases (blanked only when the macro is defined).
        digits4 = 16'h0005;
        digits1 = 16'h0005;
        for (int i = 0; i < 16; i++) step("zeros5");
        digits4 = 16'h0000;
        digits1 = 16'h0000;
        for (int i = 0; i < 16; i++) step("zeros0");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
